mmix_mem_arbiter: RTL
=====================

# mmix_mem_arbiter

Two-port arbiter that shares the single MMIX memory bus (address/datasize/read/write/done handshake) between the CPU core (port 0) and a secondary master such as the boot loader or debug port (port 1). It sits between the requesters and the memory controller. It grants one transaction at a time with round-robin fairness, registers the winning request onto the memory side, and routes completion and read data back to the winner. A watchdog terminates transactions that the memory side never completes.

## Interface

Parameters:
- TIMEOUT, 1024: cycles to wait for mem_done before forcing an error completion. 0 disables the watchdog.
- CNT_W, 16: width of the watchdog counter. TIMEOUT must be < 2^CNT_W.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_address / m1_address  in  64  requester byte address
- m0_datasize / m1_datasize  in  2  0 byte, 1 wyde, 2 tetra, 3 octa
- m0_read / m1_read  in  1  read request, level, held until mN_done
- m0_write / m1_write  in  1  write request, level, held until mN_done
- m0_writedata / m1_writedata  in  64  write data
- m0_readdata / m1_readdata  out  64  read data, valid when mN_done=1, held afterwards
- m0_done / m1_done  out  1  one-cycle completion pulse
- m0_err / m1_err  out  1  qualifies mN_done: 1 means the transaction timed out
- mem_address  out  64  registered address to memory
- mem_datasize  out  2  registered size
- mem_read / mem_write  out  1  registered strobes, held until mem_done or timeout
- mem_writedata  out  64  registered write data
- mem_readdata  in  64  memory read data, valid with mem_done
- mem_done  in  1  one-cycle completion from memory
- busy  out  1  high in BUSY and RESP
- grant_id  out  1  port owning the current or last transaction

## Operation

- FSM states: IDLE, BUSY, RESP.
- IDLE: compute req0 = m0_read|m0_write and req1 = m1_read|m1_write.
  - Only one port requesting: that port is granted.
  - Both requesting: the port not equal to last_grant is granted.
  - On grant, latch address, datasize, writedata and the op into the mem_* registers, set grant_id and last_grant, clear the watchdog counter, then go to BUSY.
- Op selection: if a port asserts read and write together, it is a write.
- BUSY: mem_read or mem_write stays high. The counter increments each cycle.
  - mem_done=1: capture mem_readdata into the winner's readdata register (read ops only), drop the mem strobes, go to RESP with err=0.
  - TIMEOUT≠0 and counter reaches TIMEOUT-1 without mem_done: drop the mem strobes, load the winner's readdata with all ones (read ops only), go to RESP with err=1.
  - If mem_done arrives in the same cycle as the timeout, mem_done wins and err=0.
- RESP: the winner's mN_done is 1 for exactly this cycle, and mN_err carries the error flag. Then go to IDLE.
  - No grant is made in RESP. This guarantees the held request that is being answered is never re-sampled.
- mem_done received in IDLE or RESP is ignored.
- The loser's outputs are unchanged while the other port is served. Readdata registers are per port and keep their value until that port's next read completion.
- Write ops leave the winner's readdata unchanged.

## Timing

- Reset (asynchronous assert, synchronous release):
  - state=IDLE, last_grant=1 (so port 0 wins the first tie), grant_id=0.
  - All mem_* outputs 0; mN_readdata 0; mN_done, mN_err and busy 0.
  - Reset mid-transaction drops the transaction silently, with no done pulse.
- Latency, with the request first visible in IDLE at cycle c:
  - mem strobe high in c+1.
  - If mem_done arrives in cycle k ≥ c+1, mN_done is high in k+1 and the FSM is in IDLE at k+2.
  - Minimum request-to-done latency is 2 cycles. Minimum back-to-back spacing is 3 cycles per transaction.
- Timeout path: the strobe is high for TIMEOUT cycles, and mN_done with err=1 follows in the next cycle.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan

- Single CPU read of octa at 0x2dd808, memory returns 0x0123456789ABCDEF after 3 cycles:
  - mem_read high for 3 cycles with mem_address=0x2dd808 and datasize=3.
  - m0_done pulses once with m0_readdata=0x0123456789ABCDEF and m0_err=0; m1_done stays 0.
- Port 1 write of tetra 0xDEADBEEF at 0x1000:
  - mem_write=1 with mem_writedata=0xDEADBEEF and mem_datasize=2.
  - m1_done pulses once; m0_readdata is unchanged.
- Both ports request reads continuously, memory with 1-cycle done:
  - Grants alternate 0,1,0,1 starting with 0.
  - Each done pulse goes to the correct port, and there is one idle cycle between transactions.
- Memory never answers with TIMEOUT=8:
  - mem_read is high exactly 8 cycles, then m0_done=1 with m0_err=1 and m0_readdata=all ones.
  - The next request is served normally.
- mem_done in the same cycle the counter hits TIMEOUT-1: completion with err=0 and the real data.
- Reset asserted during BUSY:
  - All outputs go to 0 immediately and no done pulse is produced.
  - After release, the first tie is granted to port 0.

Source files
------------

// File: rtl/mmix_mem_arbiter.sv
// Round-robin arbiter sharing the MMIX memory bus between two masters,
// with registered memory-side requests and a watchdog for unanswered transactions.
module mmix_mem_arbiter #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [63:0] m0_address,
    input  logic [1:0]  m0_datasize,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [63:0] m0_writedata,
    output logic [63:0] m0_readdata,
    output logic        m0_done,
    output logic        m0_err,
    input  logic [63:0] m1_address,
    input  logic [1:0]  m1_datasize,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [63:0] m1_writedata,
    output logic [63:0] m1_readdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic [63:0] mem_address,
    output logic [1:0]  mem_datasize,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_writedata,
    input  logic [63:0] mem_readdata,
    input  logic        mem_done,
    output logic        busy,
    output logic        grant_id
);
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = 2;
    localparam logic        WD_EN    = (TIMEOUT != 32'd0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             req0, req1, start, gnt_port, sel_write, timeout_hit, finish;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    fin_data;

    logic [AW-1:0] mem_address_d;
    logic [SW-1:0] mem_datasize_d;
    logic          mem_read_d, mem_write_d;
    logic [DW-1:0] mem_writedata_d;
    logic [DW-1:0] m0_readdata_d, m1_readdata_d;
    logic          m0_done_d, m1_done_d, m0_err_d, m1_err_d;
    logic          busy_d, grant_id_d;

    // Request decode; on a tie the port that did not win last time is chosen.
    always_comb begin
        req0        = m0_read | m0_write;
        req1        = m1_read | m1_write;
        start       = (state_q == IDLE) && (req0 || req1);
        gnt_port    = (req0 && req1) ? ~last_grant_q : req1;
        sel_write   = gnt_port ? m1_write : m0_write;
        timeout_hit = WD_EN && (cnt_q == CNT_LAST);
        finish      = mem_done || timeout_hit;
        fin_data    = mem_done ? mem_readdata : '1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)  state_d = BUSY;
            BUSY:    if (finish) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values for every registered output; mem_done outside BUSY is ignored.
    always_comb begin
        mem_address_d   = mem_address;
        mem_datasize_d  = mem_datasize;
        mem_read_d      = mem_read;
        mem_write_d     = mem_write;
        mem_writedata_d = mem_writedata;
        m0_readdata_d   = m0_readdata;
        m1_readdata_d   = m1_readdata;
        m0_done_d       = 1'b0;
        m1_done_d       = 1'b0;
        m0_err_d        = 1'b0;
        m1_err_d        = 1'b0;
        grant_id_d      = grant_id;
        last_grant_d    = last_grant_q;
        cnt_d           = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    mem_address_d   = gnt_port ? m1_address   : m0_address;
                    mem_datasize_d  = gnt_port ? m1_datasize  : m0_datasize;
                    mem_writedata_d = gnt_port ? m1_writedata : m0_writedata;
                    mem_write_d     = sel_write;
                    mem_read_d      = ~sel_write;
                    grant_id_d      = gnt_port;
                    last_grant_d    = gnt_port;
                    cnt_d           = '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (finish) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_read) begin
                        if (grant_id) m1_readdata_d = fin_data;
                        else          m0_readdata_d = fin_data;
                    end
                    if (grant_id) begin
                        m1_done_d = 1'b1;
                        m1_err_d  = ~mem_done;
                    end else begin
                        m0_done_d = 1'b1;
                        m0_err_d  = ~mem_done;
                    end
                end
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_address   <= '0;
            mem_datasize  <= '0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            m0_readdata   <= '0;
            m1_readdata   <= '0;
            m0_done       <= 1'b0;
            m1_done       <= 1'b0;
            m0_err        <= 1'b0;
            m1_err        <= 1'b0;
            busy          <= 1'b0;
            grant_id      <= 1'b0;
            last_grant_q  <= 1'b1;
            cnt_q         <= '0;
        end else begin
            mem_address   <= mem_address_d;
            mem_datasize  <= mem_datasize_d;
            mem_read      <= mem_read_d;
            mem_write     <= mem_write_d;
            mem_writedata <= mem_writedata_d;
            m0_readdata   <= m0_readdata_d;
            m1_readdata   <= m1_readdata_d;
            m0_done       <= m0_done_d;
            m1_done       <= m1_done_d;
            m0_err        <= m0_err_d;
            m1_err        <= m1_err_d;
            busy          <= busy_d;
            grant_id      <= grant_id_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule
